// File: rtl/mod_latch_bank.sv
// Clocked multi-channel capture bank: snapshots crit-gated channel words and
// hands each snapshot downstream over valid/ready, flagging overwritten snapshots.
//
// state | meaning
// EMPTY | no snapshot pending downstream
// FULL  | snapshot held on dataOut, outValid=1
module mod_latch_bank #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int EDGE_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic [CHANNELS*WIDTH-1:0] dataIn,
  input  logic [CHANNELS-1:0]       chanEn,
  input  logic                      crit,
  output logic [CHANNELS*WIDTH-1:0] dataOut,
  output logic                      outValid,
  input  logic                      outReady,
  output logic                      overrun,
  input  logic                      clrOverrun,
  output logic [15:0]               capCount
);

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic EDGE = (EDGE_MODE != 0);

  state_t state;
  logic   critQ;
  logic   cap;

  // In level mode critQ is masked off, so cap simply follows crit.
  always_comb begin
    cap = crit & ~(critQ & EDGE);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= EMPTY;
      outValid <= 1'b0;
      critQ    <= 1'b0;
      dataOut  <= '0;
      overrun  <= 1'b0;
      capCount <= 16'd0;
    end else begin
      critQ <= crit;

      if (cap) begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (chanEn[k]) begin
            dataOut[k*WIDTH +: WIDTH] <= dataIn[k*WIDTH +: WIDTH];
          end
        end
        capCount <= capCount + 16'd1;
      end

      // Set has priority over a coincident clear.
      if (state == FULL && !outReady && cap) begin
        overrun <= 1'b1;
      end else if (clrOverrun) begin
        overrun <= 1'b0;
      end

      case (state)
        EMPTY: begin
          if (cap) begin
            state    <= FULL;
            outValid <= 1'b1;
          end
        end
        FULL: begin
          if (outReady && !cap) begin
            state    <= EMPTY;
            outValid <= 1'b0;
          end
        end
        default: begin
          state    <= EMPTY;
          outValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_latch_bank.sv
// Directed bench for mod_latch_bank: a level-mode and an edge-mode instance
// share data/handshake inputs but have separate crit strobes.
module tb_mod_latch_bank;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] dataIn;
  logic [3:0]  chanEn;
  logic        crit, critE;
  logic        outReady, clrOverrun;

  logic [31:0] dataOut0, dataOut1;
  logic        outValid0, outValid1, overrun0, overrun1;
  logic [15:0] capCount0, capCount1;

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  mod_latch_bank #(.WIDTH(8), .CHANNELS(4), .EDGE_MODE(0)) dutLevel (
    .clk(clk), .rstN(rstN), .dataIn(dataIn), .chanEn(chanEn), .crit(crit),
    .dataOut(dataOut0), .outValid(outValid0), .outReady(outReady),
    .overrun(overrun0), .clrOverrun(clrOverrun), .capCount(capCount0));

  mod_latch_bank #(.WIDTH(8), .CHANNELS(4), .EDGE_MODE(1)) dutEdge (
    .clk(clk), .rstN(rstN), .dataIn(dataIn), .chanEn(chanEn), .crit(critE),
    .dataOut(dataOut1), .outValid(outValid1), .outReady(outReady),
    .overrun(overrun1), .clrOverrun(clrOverrun), .capCount(capCount1));

  typedef struct {
    logic [31:0] din;
    logic [3:0]  en;
    logic        cr;
    logic        rdy;
    logic        clr;
    logic [31:0] expData;
    logic        expValid;
    logic        expOvr;
    logic [15:0] expCnt;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'hA1B2C3D4, 4'hF, 1'b1, 1'b1, 1'b0, 32'hA1B2C3D4, 1'b1, 1'b0, 16'd1};
    vecs[1]  = '{32'hA1B2C3D4, 4'hF, 1'b0, 1'b1, 1'b0, 32'hA1B2C3D4, 1'b0, 1'b0, 16'd1};
    vecs[2]  = '{32'h11223344, 4'h5, 1'b1, 1'b1, 1'b0, 32'hA122C344, 1'b1, 1'b0, 16'd2};
    vecs[3]  = '{32'h11223344, 4'h5, 1'b0, 1'b1, 1'b0, 32'hA122C344, 1'b0, 1'b0, 16'd2};
    vecs[4]  = '{32'h00000001, 4'h1, 1'b1, 1'b0, 1'b0, 32'hA122C301, 1'b1, 1'b0, 16'd3};
    vecs[5]  = '{32'h00000002, 4'h1, 1'b1, 1'b0, 1'b0, 32'hA122C302, 1'b1, 1'b1, 16'd4};
    vecs[6]  = '{32'h00000003, 4'h1, 1'b1, 1'b0, 1'b1, 32'hA122C303, 1'b1, 1'b1, 16'd5};
    vecs[7]  = '{32'h000000FF, 4'h1, 1'b0, 1'b0, 1'b1, 32'hA122C303, 1'b1, 1'b0, 16'd5};
    vecs[8]  = '{32'h000000EE, 4'h1, 1'b0, 1'b0, 1'b0, 32'hA122C303, 1'b1, 1'b0, 16'd5};
    vecs[9]  = '{32'h55667788, 4'hF, 1'b1, 1'b1, 1'b0, 32'h55667788, 1'b1, 1'b0, 16'd6};
    vecs[10] = '{32'h55667788, 4'hF, 1'b0, 1'b1, 1'b0, 32'h55667788, 1'b0, 1'b0, 16'd6};
    vecs[11] = '{32'h01020304, 4'hF, 1'b1, 1'b1, 1'b0, 32'h01020304, 1'b1, 1'b0, 16'd7};
    vecs[12] = '{32'h0A0B0C0D, 4'hF, 1'b1, 1'b1, 1'b0, 32'h0A0B0C0D, 1'b1, 1'b0, 16'd8};
    vecs[13] = '{32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0A0B0C0D, 1'b1, 1'b0, 16'd8};
    vecs[14] = '{32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0A0B0C0D, 1'b0, 1'b0, 16'd8};

    rstN = 1'b0; dataIn = 32'hA1B2C3D4; chanEn = 4'hF; crit = 1'b1; critE = 1'b0;
    outReady = 1'b1; clrOverrun = 1'b0;
    tick(); tick();
    check("rst_data",  dataOut0, 32'h0);
    check("rst_valid", {31'b0, outValid0}, 32'h0);
    check("rst_ovr",   {31'b0, overrun0}, 32'h0);
    check("rst_cnt",   {16'b0, capCount0}, 32'h0);

    rstN = 1'b1;
    for (int i = 0; i < 15; i++) begin
      dataIn = vecs[i].din; chanEn = vecs[i].en; crit = vecs[i].cr;
      outReady = vecs[i].rdy; clrOverrun = vecs[i].clr;
      tick();
      check($sformatf("v%0d_data", i),  dataOut0, vecs[i].expData);
      check($sformatf("v%0d_valid", i), {31'b0, outValid0}, {31'b0, vecs[i].expValid});
      check($sformatf("v%0d_ovr", i),   {31'b0, overrun0}, {31'b0, vecs[i].expOvr});
      check($sformatf("v%0d_cnt", i),   {16'b0, capCount0}, {16'b0, vecs[i].expCnt});
    end
    crit = 1'b0; clrOverrun = 1'b0; outReady = 1'b1; chanEn = 4'hF;

    // Edge mode: crit held high over changing data yields one capture.
    for (int i = 1; i <= 5; i++) begin
      dataIn = i; critE = 1'b1;
      tick();
      if (i == 1) check("edge_first", dataOut1, 32'd1);
    end
    check("edge_hold_data", dataOut1, 32'd1);
    check("edge_hold_cnt",  {16'b0, capCount1}, 32'd1);
    critE = 1'b0; tick();
    critE = 1'b1; dataIn = 32'd9; tick();
    check("edge_second_data", dataOut1, 32'd9);
    check("edge_second_cnt",  {16'b0, capCount1}, 32'd2);

    // Reset with crit already high: edge instance captures on the first edge.
    rstN = 1'b0; #2;
    check("rst2_cnt", {16'b0, capCount1}, 32'd0);
    dataIn = 32'h000000AA; crit = 1'b1; critE = 1'b1; outReady = 1'b1;
    rstN = 1'b1;
    tick();
    check("edge_rel_data", dataOut1, 32'h000000AA);
    check("edge_rel_cnt",  {16'b0, capCount1}, 32'd1);
    check("lvl_rel_cnt",   {16'b0, capCount0}, 32'd1);
    repeat (65534) @(posedge clk);
    #1;
    check("cnt_ffff",      {16'b0, capCount0}, 32'h0000FFFF);
    check("edge_long_cnt", {16'b0, capCount1}, 32'd1);
    tick();
    check("cnt_wrap", {16'b0, capCount0}, 32'h0);
    outReady = 1'b0; dataIn = 32'h12345678;
    tick();
    check("pre_rst_ovr",   {31'b0, overrun0}, 32'h1);
    check("pre_rst_valid", {31'b0, outValid0}, 32'h1);
    check("pre_rst_data",  dataOut0, 32'h12345678);

    #2 rstN = 1'b0;
    #1;
    check("async_data",  dataOut0, 32'h0);
    check("async_valid", {31'b0, outValid0}, 32'h0);
    check("async_ovr",   {31'b0, overrun0}, 32'h0);
    check("async_cnt",   {16'b0, capCount0}, 32'h0);
    tick();
    check("rst_hold_cnt", {16'b0, capCount0}, 32'h0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/mod_latch_bank.md
Name: mod_latch_bank

Overview:
Parametrised, clocked successor to the single-bit D latch. It captures CHANNELS words of WIDTH bits, gated by the crit strobe with per-channel enables, in one of two capture modes. Each snapshot is presented downstream through a valid/ready handshake, and the block flags any snapshot that overwrites an unconsumed one. It sits between the sensor/neuron input fabric and the neuron update logic.

Parameters:
WIDTH, 8, bits per channel (>=1)
CHANNELS, 4, number of channels (>=1)
EDGE_MODE, 0, 0 = level capture (every clk while crit=1); 1 = edge capture (one capture per crit 0->1 transition)

Ports:
clk  input  1  rising-edge clock; the only clock
rstN  input  1  asynchronous active-low reset
dataIn  input  CHANNELS*WIDTH  packed channel inputs; channel k occupies [k*WIDTH +: WIDTH]
chanEn  input  CHANNELS  per-channel capture enable; bit k gates channel k
crit  input  1  capture strobe (level or edge per EDGE_MODE)
dataOut  output  CHANNELS*WIDTH  held snapshot, same packing as dataIn
outValid  output  1  snapshot available
outReady  input  1  downstream accepts snapshot when outValid=1
overrun  output  1  sticky flag: a capture replaced an unaccepted snapshot
clrOverrun  input  1  synchronous clear of overrun
capCount  output  16  number of captures since reset, wraps

Behaviour:
- Reset (rstN=0, asynchronous): dataOut=0, outValid=0, overrun=0, capCount=0, critQ=0, state=EMPTY. Outputs hold these values while rstN=0. Release is synchronous to clk: the first capture is possible on the first rising edge after rstN=1.
- Capture event (cap), evaluated at the clk edge:
  - EDGE_MODE=0: cap = crit.
  - EDGE_MODE=1: cap = crit & ~critQ, where critQ is crit registered every cycle.
  - EDGE_MODE=1 with crit already high at reset release: critQ=0, so a capture occurs on the first edge.
- On cap: for each k with chanEn[k]=1, dataOut channel k <= dataIn channel k. Channels with chanEn[k]=0 hold their value. capCount <= capCount+1, wrapping 0xFFFF->0. A cap with chanEn=0 (all bits clear) still counts and still sets outValid.
- Latency: data sampled at edge N appears on dataOut after edge N. There is no combinational path from dataIn to dataOut.
- State machine, 2 states, outValid=1 iff state=FULL:
  - EMPTY: cap -> FULL. No cap -> EMPTY.
  - FULL, outReady=1, no cap -> EMPTY (handshake complete).
  - FULL, outReady=1, cap -> FULL. The old snapshot is accepted this edge and the new one is loaded. No overrun.
  - FULL, outReady=0, cap -> FULL. The snapshot is overwritten and overrun <= 1.
  - FULL, outReady=0, no cap -> FULL. dataOut stable.
- Handshake rule: while outValid=1 and outReady=0, dataOut changes only on cap, and that case always sets overrun. Downstream may hold outReady high permanently.
- overrun: set as above and cleared by clrOverrun. If set and clear fall on the same edge, set wins.
- Level mode with crit held high: captures every cycle, tracking dataIn with 1-cycle delay. This is the clocked equivalent of a transparent latch. outValid stays 1. Overrun sets whenever outReady=0 in a following cycle.
- Reset mid-operation: an immediate return to reset values. Any pending snapshot is discarded and not reported.
- Width rules: WIDTH and CHANNELS are generic. capCount is fixed at 16 bits. No arithmetic on data.

Test Plan:
1. Reset/level capture: WIDTH=8, CHANNELS=4, EDGE_MODE=0. Hold rstN=0 with crit=1, then release; dataIn=0xA1B2C3D4, chanEn=4'hF, outReady=1, one-cycle crit pulse -> dataOut=0xA1B2C3D4 one edge after, outValid=1 for that cycle then 0, capCount=1, overrun=0.
2. Per-channel enable: dataOut=0xA1B2C3D4, then dataIn=0x11223344, chanEn=4'b0101, crit pulse -> dataOut=0xA122C344.
3. Edge mode: EDGE_MODE=1, crit held high for 5 cycles while dataIn increments 1..5 -> exactly one capture (value 1), capCount=1. Drop crit, raise again with dataIn=9 -> dataOut=9, capCount=2.
4. Overrun: outReady=0, two captures 0x01 then 0x02 on channel 0 -> outValid=1, dataOut ch0=0x02, overrun=1. Assert clrOverrun together with a third capture -> overrun stays 1. clrOverrun alone -> 0.
5. Accept-and-reload: FULL with outReady=1 and cap on the same edge -> outValid stays 1, new data loaded, overrun=0. Next edge with no cap -> outValid=0.
6. Async reset mid-operation and wrap: preload capCount to 0xFFFF via 65535 level-mode cycles, one more cap -> capCount=0. Assert rstN=0 between clk edges while FULL -> dataOut, outValid, overrun and capCount go to 0 immediately, before the next edge.
